// File: rtl/cordic_algorithm.sv
// Fully pipelined unified CORDIC (circular / linear / hyperbolic, rotation / vectoring).
// One sample per clock, N_ITERATION clocks of latency, no gain compensation.
module cordic_algorithm #(
  parameter int N_ITERATION     = 12,
  parameter int INTEGER_BITS    = 8,
  parameter int FRACTIONAL_BITS = 24
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0] i_x,
  input  logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0] i_y,
  input  logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0] i_z,
  input  logic        [1:0]                             i_mode,
  input  logic                                          i_rot_en,
  output logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0] o_x,
  output logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0] o_y,
  output logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0] o_z
);

  localparam int W = INTEGER_BITS + FRACTIONAL_BITS;
  // Guard precision used when deriving the angle tables at elaboration.
  localparam int G = 62;

  localparam logic [1:0] ModeCirc = 2'b01;
  localparam logic [1:0] ModeHyp  = 2'b11;

  // Hyperbolic shift for stage k: starts at 1, shifts 4, 13, 40, ... are taken twice.
  function automatic int hyp_shift(int k);
    int s;
    int rep;
    bit done;
    s    = 1;
    rep  = 4;
    done = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (s == rep && !done) begin
        done = 1'b1;
      end else begin
        if (s == rep) begin
          rep  = 3 * rep + 1;
          done = 1'b0;
        end
        s = s + 1;
      end
    end
    return s;
  endfunction

  // Sum of t^(2n+1)/(2n+1) with t = 1/q, scaled by 2^G; alternating sign gives atan.
  function automatic longint arc_series(longint q, bit hyp);
    longint pw;
    longint term;
    longint sum;
    sum = 0;
    pw  = (64'sd1 <<< G) / q;
    for (int n = 0; n < 64; n++) begin
      term = pw / longint'(2 * n + 1);
      if (!hyp && (n % 2 == 1)) sum = sum - term;
      else                      sum = sum + term;
      pw = pw / q / q;
    end
    return sum;
  endfunction

  function automatic logic signed [W-1:0] to_q(longint v);
    longint r;
    r = (v + (64'sd1 <<< (G - FRACTIONAL_BITS - 1))) >>> (G - FRACTIONAL_BITS);
    return W'(r);
  endfunction

  function automatic logic signed [W-1:0] circ_angle(int s);
    // atan(1) via Machin's formula since the power series converges too slowly at t = 1.
    if (s == 0) return to_q(4 * arc_series(64'sd5, 1'b0) - arc_series(64'sd239, 1'b0));
    if (s >= G) return '0;
    return to_q(arc_series(64'sd1 <<< s, 1'b0));
  endfunction

  function automatic logic signed [W-1:0] lin_angle(int s);
    if (s >= G) return '0;
    return to_q(64'sd1 <<< (G - s));
  endfunction

  function automatic logic signed [W-1:0] hyp_angle(int s);
    if (s >= G) return '0;
    return to_q(arc_series(64'sd1 <<< s, 1'b1));
  endfunction

  for (genvar k = 0; k < N_ITERATION; k++) begin : g_stage
    localparam int                     ShC  = k;
    localparam int                     ShH  = hyp_shift(k);
    localparam logic signed [W-1:0]    AngC = circ_angle(ShC);
    localparam logic signed [W-1:0]    AngL = lin_angle(ShC);
    localparam logic signed [W-1:0]    AngH = hyp_angle(ShH);

    logic signed [W-1:0] x_in, y_in, z_in;
    logic        [1:0]   mode_in;
    logic                rot_in;
    logic signed [W-1:0] x_sh, y_sh, ang;
    logic signed [W-1:0] x_d, y_d, z_d;
    logic signed [W-1:0] x_q, y_q, z_q;
    logic        [1:0]   mode_q;
    logic                rot_q;
    logic                d_pos;

    if (k == 0) begin : g_first
      assign x_in    = i_x;
      assign y_in    = i_y;
      assign z_in    = i_z;
      assign mode_in = i_mode;
      assign rot_in  = i_rot_en;
    end else begin : g_next
      assign x_in    = g_stage[k-1].x_q;
      assign y_in    = g_stage[k-1].y_q;
      assign z_in    = g_stage[k-1].z_q;
      assign mode_in = g_stage[k-1].mode_q;
      assign rot_in  = g_stage[k-1].rot_q;
    end

    always_comb begin
      d_pos = rot_in ? ~z_in[W-1] : y_in[W-1];
      x_sh  = (mode_in == ModeHyp) ? (x_in >>> ShH) : (x_in >>> ShC);
      y_sh  = (mode_in == ModeHyp) ? (y_in >>> ShH) : (y_in >>> ShC);
      x_d   = x_in;
      ang   = AngL;
      // Codes 0 and -2 both fall to linear: x is untouched.
      case (mode_in)
        ModeCirc: begin
          ang = AngC;
          x_d = d_pos ? x_in - y_sh : x_in + y_sh;
        end
        ModeHyp: begin
          ang = AngH;
          x_d = d_pos ? x_in + y_sh : x_in - y_sh;
        end
        default: ;
      endcase
      y_d = d_pos ? y_in + x_sh : y_in - x_sh;
      z_d = d_pos ? z_in - ang : z_in + ang;
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        x_q    <= '0;
        y_q    <= '0;
        z_q    <= '0;
        mode_q <= '0;
        rot_q  <= 1'b0;
      end else begin
        x_q    <= x_d;
        y_q    <= y_d;
        z_q    <= z_d;
        mode_q <= mode_in;
        rot_q  <= rot_in;
      end
    end
  end

  assign o_x = g_stage[N_ITERATION-1].x_q;
  assign o_y = g_stage[N_ITERATION-1].y_q;
  assign o_z = g_stage[N_ITERATION-1].z_q;

endmodule

// File: tb/tb_cordic_algorithm.sv
// Bench for cordic_algorithm: directed and random samples streamed every cycle,
// checked against closed-form trig/hyperbolic results scaled by the CORDIC gains.
module tb_cordic_algorithm;

  localparam int  N     = 12;
  localparam int  IB    = 8;
  localparam int  FB    = 24;
  localparam int  W     = IB + FB;
  localparam real SCALE = 16777216.0;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] x_in, y_in, z_in;
  logic [1:0]   mode_in;
  logic         rot_in;
  logic [W-1:0] x_out, y_out, z_out;

  always #5 clk = ~clk;

  cordic_algorithm #(
    .N_ITERATION    (N),
    .INTEGER_BITS   (IB),
    .FRACTIONAL_BITS(FB)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_x     (x_in),
    .i_y     (y_in),
    .i_z     (z_in),
    .i_mode  (mode_in),
    .i_rot_en(rot_in),
    .o_x     (x_out),
    .o_y     (y_out),
    .o_z     (z_out)
  );

  typedef struct {
    bit           bubble;
    bit           exact_x;
    logic [W-1:0] xr;
    real          ex, ey, ez;
    real          tx, ty, tz;
    string        tag;
  } exp_t;

  exp_t pipe[$];
  int   tests = 0;
  int   fails = 0;
  real  gain_a, gain_k;

  function automatic logic [W-1:0] to_fx(real v);
    return W'($rtoi(v * SCALE));
  endfunction

  function automatic real fx(logic [W-1:0] v);
    return $itor($signed(v)) / SCALE;
  endfunction

  function automatic real rnd(real lo, real hi);
    return lo + (hi - lo) * ($itor($urandom_range(0, 1000000)) / 1.0e6);
  endfunction

  function automatic real absr(real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // Expected result from the closed-form functions each mode evaluates.
  function automatic exp_t model(logic [W-1:0] xr, logic [W-1:0] yr, logic [W-1:0] zr,
                                 int mode, bit rot, real ztol);
    exp_t e;
    real x, y, z, mag;
    x = fx(xr);
    y = fx(yr);
    z = fx(zr);
    e.bubble  = 1'b0;
    e.exact_x = 1'b0;
    e.xr      = xr;
    e.tx      = 0.01;
    e.ty      = 0.01;
    e.tz      = ztol;
    if (mode == 1) begin
      e.tag = rot ? "circ_rot" : "circ_vec";
      if (rot) begin
        e.ex = gain_a * (x * $cos(z) - y * $sin(z));
        e.ey = gain_a * (y * $cos(z) + x * $sin(z));
        e.ez = 0.0;
      end else begin
        e.ex = gain_a * $sqrt(x * x + y * y);
        e.ey = 0.0;
        e.ez = z + $atan(y / x);
      end
    end else if (mode == -1) begin
      e.tag = rot ? "hyp_rot" : "hyp_vec";
      if (rot) begin
        e.ex = gain_k * (x * $cosh(z) + y * $sinh(z));
        e.ey = gain_k * (y * $cosh(z) + x * $sinh(z));
        e.ez = 0.0;
      end else begin
        e.ex = gain_k * $sqrt(x * x - y * y);
        e.ey = 0.0;
        e.ez = z + $atanh(y / x);
      end
    end else begin
      e.tag     = rot ? "lin_rot" : "lin_vec";
      e.exact_x = 1'b1;
      e.ex      = x;
      if (rot) begin
        e.ey = y + x * z;
        e.ez = 0.0;
      end else begin
        e.ey = 0.0;
        e.ez = z + y / x;
      end
    end
    // Vectoring leaves a y residue proportional to the final x magnitude.
    if (!rot) begin
      mag = absr(e.ex) * (2.0 ** (-(N - 2)));
      if (mag > e.ty) e.ty = mag;
    end
    return e;
  endfunction

  task automatic check_val(string tag, real got, real exp, real tol);
    bit ok;
    tests++;
    ok = (got - exp <= tol) && (exp - got <= tol);
    assert (ok === 1'b1) else begin
      fails++;
      $error("FAIL %s: got %f, expected %f (tol %f)", tag, got, exp, tol);
    end
  endtask

  task automatic check_bits(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic compare(exp_t e);
    if (e.bubble) begin
      check_bits("idle_x", x_out, '0);
      check_bits("idle_y", y_out, '0);
    end else begin
      if (e.exact_x) check_bits({e.tag, "_x"}, x_out, e.xr);
      else           check_val({e.tag, "_x"}, fx(x_out), e.ex, e.tx);
      check_val({e.tag, "_y"}, fx(y_out), e.ey, e.ty);
      check_val({e.tag, "_z"}, fx(z_out), e.ez, e.tz);
    end
  endtask

  // One clock: drive a sample, then check whatever is due on the outputs.
  task automatic tick(bit do_rst, logic [W-1:0] xr, logic [W-1:0] yr, logic [W-1:0] zr,
                      int mode, bit rot, real ztol);
    exp_t b;
    rst     = do_rst;
    x_in    = xr;
    y_in    = yr;
    z_in    = zr;
    mode_in = mode[1:0];
    rot_in  = rot;
    @(posedge clk);
    #1;
    if (do_rst) begin
      check_bits("rst_x", x_out, '0);
      check_bits("rst_y", y_out, '0);
      check_bits("rst_z", z_out, '0);
      pipe.delete();
      b.bubble = 1'b1;
      for (int i = 0; i < N - 1; i++) pipe.push_back(b);
    end else begin
      pipe.push_back(model(xr, yr, zr, mode, rot, ztol));
      if (pipe.size() == N) compare(pipe.pop_front());
    end
  endtask

  task automatic directed(real x, real y, real z, int mode, bit rot, real ztol);
    tick(1'b0, to_fx(x), to_fx(y), to_fx(z), mode, rot, ztol);
  endtask

  task automatic random_tick(bit do_rst);
    int  mode;
    bit  rot;
    real x, y, z;
    mode = $urandom_range(0, 3) - 2;
    rot  = 1'($urandom_range(0, 1));
    if (mode == 1) begin
      if (rot) begin x = rnd(-2.0, 2.0); y = rnd(-2.0, 2.0); z = rnd(-1.5, 1.5); end
      else     begin x = rnd(0.5, 3.0);  y = rnd(-3.0, 3.0); z = rnd(-0.5, 0.5); end
    end else if (mode == -1) begin
      if (rot) begin x = rnd(-1.0, 1.0); y = rnd(-1.0, 1.0); z = rnd(-1.0, 1.0); end
      else     begin x = rnd(1.0, 2.0);  y = x * rnd(-0.7, 0.7); z = rnd(-0.2, 0.2); end
    end else begin
      if (rot) begin x = rnd(-4.0, 4.0); y = rnd(-4.0, 4.0); z = rnd(-1.9, 1.9); end
      else     begin x = rnd(1.0, 4.0);  y = x * rnd(-1.9, 1.9); z = rnd(-0.5, 0.5); end
    end
    tick(do_rst, to_fx(x), to_fx(y), to_fx(z), mode, rot, 0.01);
  endtask

  initial begin
    int  hs[$];
    int  s;
    gain_a = 1.0;
    for (int k = 0; k < N; k++) gain_a = gain_a * $sqrt(1.0 + 2.0 ** (-2 * k));
    s = 1;
    while (hs.size() < N) begin
      hs.push_back(s);
      if ((s == 4 || s == 13 || s == 40) && hs.size() < N) hs.push_back(s);
      s++;
    end
    gain_k = 1.0;
    foreach (hs[i]) gain_k = gain_k * $sqrt(1.0 - 2.0 ** (-2 * hs[i]));

    // Reset with nonzero inputs on the bus.
    tick(1'b1, to_fx(1.5), to_fx(-2.25), to_fx(0.75), 1, 1'b1, 0.01);

    // Directed samples streamed back to back with alternating rot_en.
    directed(6.0,  5.0, 0.5,    0, 1'b1, 0.01);
    directed(81.0, 10.0, 0.0,   0, 1'b0, 0.002);
    directed(1.0,  0.0, 0.5236, 1, 1'b1, 0.01);
    directed(3.0,  3.0, 0.0,    1, 1'b0, 0.01);
    directed(1.0,  0.0, 0.5,   -1, 1'b1, 0.01);
    directed(2.0,  1.0, 0.0,   -1, 1'b0, 0.01);
    directed(6.0,  5.0, 0.5,   -2, 1'b1, 0.01);
    directed(81.0, 10.0, 0.0,  -2, 1'b0, 0.002);

    for (int i = 0; i < 150; i++) random_tick(1'b0);

    // Reset in the middle of a full pipeline: in-flight samples must vanish.
    random_tick(1'b1);
    for (int i = 0; i < 60; i++) random_tick(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cordic_algorithm.md
Name: cordic_algorithm

Overview:
- Fully pipelined unified CORDIC engine in signed fixed point.
- Covers circular, linear and hyperbolic coordinate systems, each in rotation or vectoring mode, with the mode selected per sample.
- Accepts one new sample every clock and returns its result exactly N_ITERATION clocks later.
- Serves as the shared math core for trig, mult/div and hyperbolic functions.

Parameters:
- N_ITERATION, 12, number of micro-rotation stages; equals pipeline depth and latency.
- INTEGER_BITS, 8, integer bits including sign of the Q format.
- FRACTIONAL_BITS, 24, fractional bits of the Q format; W = INTEGER_BITS+FRACTIONAL_BITS.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_x  in  W  signed x operand, Q(INTEGER_BITS).(FRACTIONAL_BITS).
- i_y  in  W  signed y operand, same format.
- i_z  in  W  signed angle/accumulator operand; radians for circular and hyperbolic.
- i_mode  in  2  signed coordinate system: -1 hyperbolic, 0 linear, +1 circular. Code -2 is treated as linear.
- i_rot_en  in  1  1 = rotation mode (drive z to 0); 0 = vectoring mode (drive y to 0).
- o_x  out  W  signed x result.
- o_y  out  W  signed y result.
- o_z  out  W  signed z result.

Behaviour:
- Clock and reset: one clock (i_clk); reset is synchronous and active-high (i_rst).
- Reset: every pipeline register, including the carried mode and rot_en, clears to 0 on the next rising edge. o_x, o_y and o_z read 0 until valid data propagates.
  - Reset asserted mid-stream discards all in-flight samples.
- Pipeline structure:
  - There is no enable or handshake; every stage advances every cycle.
  - Stage k (k = 0..N_ITERATION-1) registers x, y, z, mode and rot_en.
  - A sample presented before edge t appears on the outputs after edge t+N_ITERATION-1, i.e. N_ITERATION edges including the capturing edge.
  - Outputs are the last stage registers.
- Per-stage direction d:
  - Rotation: d = +1 if z >= 0, else -1.
  - Vectoring: d = +1 if y < 0, else -1.
- Per-stage update, with m = mode, s = shift and e = angle constant:
  - x' = x - m*d*(y >>> s)
  - y' = y + d*(x >>> s)
  - z' = z - d*e
- Shift schedule:
  - Circular and linear: s = k.
  - Hyperbolic: s = 1,2,3,4,4,5,...,13,13,... — starts at 1; shifts 4 and 13 (and 40) are executed twice; truncated to N_ITERATION stages.
- Constants e, precomputed at elaboration, rounded to nearest LSB in the same Q format:
  - Circular: atan(2^-s).
  - Linear: 2^-s.
  - Hyperbolic: atanh(2^-s).
- Arithmetic rules:
  - >>> is arithmetic shift (truncation toward -inf).
  - Add/sub are W-bit two's complement; overflow wraps, no saturation.
- No gain compensation; outputs carry the CORDIC gain.
  - Circular A ≈ 1.64676.
  - Hyperbolic K ≈ 0.8282 for N=12.
- Results:
  - Circular rotation: x = A(x0cos z0 - y0 sin z0), y = A(y0 cos z0 + x0 sin z0), z → 0.
  - Circular vectoring (x0 > 0): x = A·sqrt(x0²+y0²), y → 0, z = z0 + atan(y0/x0).
  - Linear rotation: x = x0, y = y0 + x0·z0, z → 0.
  - Linear vectoring (x0 > 0): x = x0, y → 0, z = z0 + y0/x0.
  - Hyperbolic rotation: x = K(x0cosh z0 + y0 sinh z0), y = K(y0 cosh z0 + x0 sinh z0).
  - Hyperbolic vectoring (x0 > |y0|): x = K·sqrt(x0²-y0²), z = z0 + atanh(y0/x0).
- Convergence ranges: |z0| or the quotient must stay within ±1.74 (circular), ±(2-2^-(N-1)) (linear), ±1.11 (hyperbolic).
  - Outside these ranges the output is defined only by the recurrences above, with no error flag.
- Mode and rot_en travel with the sample, so adjacent samples may use different modes.

Test Plan (INTEGER_BITS=8, FRACTIONAL_BITS=24, N_ITERATION=12, tolerance ±0.01 unless stated):
- Reset: hold i_rst for 1 cycle with nonzero inputs -> all outputs 0 on the next edge; first valid result exactly 12 cycles after the first post-reset input.
- Linear rotation x=6, y=5, z=0.5 -> o_x=6.0 exact, o_y≈8.0, o_z≈0.
- Linear vectoring x=81, y=10, z=0 -> o_x=81 exact, o_z≈0.12346 (±0.002), o_y≈0.
- Circular rotation x=1, y=0, z=0.5236 -> o_x≈1.4261, o_y≈0.8234, o_z≈0; circular vectoring x=3, y=3, z=0 -> o_x≈6.9865, o_z≈0.7854.
- Hyperbolic rotation x=1, y=0, z=0.5 -> o_x≈0.9339, o_y≈0.4316.
- Back-to-back: the above samples fed on consecutive cycles with alternating i_rot_en -> each result emerges in order, exactly 12 cycles after its input, unchanged versus isolated runs. Reset asserted mid-stream -> outputs 0 next edge, no stale results afterward.
